// File: rtl/pwm_capture.sv
// PWM period / high-time measurement receiver with a stuck-line timeout.
// pwm_in is resynchronised into sys_clk and both edges are timed in sys_clk cycles.
module pwm_capture #(
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] TIMEOUT = 20'd1_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             meas_changed,
  output logic             timeout
);

  typedef enum logic [1:0] {ST_ARM, ST_HIGH, ST_LOW, ST_TO} state_t;

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_lat;
  logic             r_first;

  logic             w_rise, w_fall, w_at_to, w_diff;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_at_to   = (r_cnt == TIMEOUT);
  // Saturate at TIMEOUT so a fall landing exactly on the limit cannot push cnt past it.
  assign w_cnt_inc = w_at_to ? r_cnt : r_cnt + CNT_W'(1);
  assign w_diff    = (r_cnt != period_out) || (r_hi_lat != high_out);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      // Sync chain resets high so a line already high at release is not a rise.
      r_s1         <= 1'b1;
      r_s2         <= 1'b1;
      r_s3         <= 1'b1;
      r_state      <= ST_ARM;
      r_cnt        <= '0;
      r_hi_lat     <= '0;
      r_first      <= 1'b1;
      period_out   <= '0;
      high_out     <= '0;
      meas_valid   <= 1'b0;
      meas_changed <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_s1         <= pwm_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      meas_valid   <= 1'b0;
      meas_changed <= 1'b0;
      case (r_state)
        ST_ARM: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_hi_lat <= r_cnt;
            r_cnt    <= w_cnt_inc;
            r_state  <= ST_LOW;
          end else if (w_at_to) begin
            r_state <= ST_TO;
            timeout <= 1'b1;
            r_first <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            period_out   <= r_cnt;
            high_out     <= r_hi_lat;
            meas_valid   <= 1'b1;
            meas_changed <= r_first | w_diff;
            r_first      <= 1'b0;
            timeout      <= 1'b0;
            r_cnt        <= CNT_W'(1);
            r_state      <= ST_HIGH;
          end else if (w_at_to) begin
            r_state <= ST_TO;
            timeout <= 1'b1;
            r_first <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_TO: begin
          if (w_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= ST_HIGH;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM measurement receiver for the pwm_generator output (or any external PWM). It synchronises an asynchronous pwm_in into the sys_clk domain and measures, in sys_clk cycles, the period (rising edge to rising edge) and the high time (rising to falling). It publishes both with a one-cycle valid strobe and a change flag, and detects a stuck line (0 %/100 % duty or lost signal) with a timeout. Used for closed-loop checks of the duty selected by key_1 and for on-board self-test.

Parameters:
CNT_W, 20, width of the counter and the measurement outputs.
TIMEOUT, 20'd1_000_000, cycles after the last rising edge with no edge before timeout is declared (20 ms at 50 MHz). Must be ≥3 and < 2^CNT_W.

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  reset; synchronous, active-low
pwm_in  input  1  asynchronous PWM input
period_out  output  CNT_W  last measured period, cycles
high_out  output  CNT_W  last measured high time, cycles
meas_valid  output  1  one-cycle strobe; new period_out/high_out this cycle
meas_changed  output  1  one-cycle strobe, only together with meas_valid: new pair differs from previous pair
timeout  output  1  level; no edge for TIMEOUT cycles

Behaviour:
- Sync chain:
  - s1→s2→s3 flops; reset value of all three = 1.
  - rise = s2 & ~s3; fall = ~s2 & s3. Never both in one cycle.
  - Reset-to-1 means a line already high at reset release produces no false rise.
- Latency: meas_valid goes high at the 3rd sys_clk edge after the edge that first samples pwm_in high. Both edges have equal delay, so measurements are exact.
- Counter cnt (CNT_W bits), states ARM, HIGH, LOW, TO:
  - ARM (reset state): falls ignored. On rise: cnt←1, go to HIGH.
  - HIGH: cnt←cnt+1. On fall: hi_lat←cnt, go to LOW.
  - LOW: cnt←cnt+1. On rise: period_out←cnt, high_out←hi_lat, meas_valid←1, cnt←1, go to HIGH.
  - HIGH/LOW with cnt==TIMEOUT and no edge this cycle: go to TO, timeout←1, cnt holds. An edge in the same cycle that cnt==TIMEOUT is processed normally (period = TIMEOUT is a valid result).
  - TO: cnt frozen. Falls ignored. On rise: cnt←1, go to HIGH; timeout stays 1.
- Counter semantics: with rise at cycle t0, cnt = k at cycle t0+k. Result: period = P, high = H exactly. Minimum measurable: high 1, low 1 (period 2).
- cnt never exceeds TIMEOUT, so no wrap-around.
- timeout clears on the same cycle meas_valid is next asserted.
- meas_changed:
  - Asserted with meas_valid when {period,high} ≠ previous pair.
  - Forced to 1 on the first meas_valid after reset or after a timeout (a "first" flag is set by reset/TO and cleared by meas_valid).
- Output hold: period_out/high_out keep their last values through LOW, HIGH and TO. They update only on meas_valid.
- Reset values:
  - period_out = 0, high_out = 0, meas_valid = 0, meas_changed = 0, timeout = 0.
  - cnt = 0, hi_lat = 0, state ARM, first flag = 1.
- Reset mid-measurement:
  - Partial counts are discarded and no meas_valid is issued.
  - Outputs return to reset values at the first clock edge with sys_rst_n low.
- Pulses narrower than one sys_clk period may be missed; no glitch filtering beyond the synchroniser.

Test Plan:
- Reset, then pwm_in period 50 / high 25 → first meas_valid at the 2nd rising edge with period_out=50, high_out=25, meas_changed=1; following strobes every 50 cycles with meas_changed=0.
- Switch to high 10 mid-stream (period 50) → first complete new period gives high_out=10, period_out=50, meas_changed=1; the transition period reports the high time actually seen.
- TIMEOUT=200; hold pwm_in low after a fall → timeout=1 exactly 200 cycles after the last rise, outputs hold 50/25. Then resume 50/25 → timeout clears with the 2nd rise; meas_changed=1.
- pwm_in held high at reset release → no meas_valid until a fall then two rises; first result is correct (no truncated high).
- Minimum pulse: period 3, high 1 → period_out=3, high_out=1 every 3 cycles. Edge case: period exactly TIMEOUT=200 → valid result, timeout stays 0.
- Assert sys_rst_n low for 1 cycle mid-HIGH → all outputs 0 next edge; the first subsequent result needs a fresh full period.
